// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit engine.
package uart_tx_pkg;

  // Frame sequencing states; any other code falls back to IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

  // Per-frame options latched together with the data word.
  typedef struct packed {
    logic par_en;
    logic par_typ;
    logic stop2;
  } frame_cfg_t;

endpackage

// File: rtl/uart_tx_parity.sv
// Parity generator: XOR reduction of the data word with odd/even select.
module uart_tx_parity
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             par_typ_i,
  output logic             parity_o
);

  // Even parity is the plain XOR of the bits; odd parity is its complement.
  always_comb begin
    parity_o = ^data_i;
    if (par_typ_i == PAR_ODD) begin
      parity_o = ~(^data_i);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: holding buffer, frame FSM, shift register and counters.
module uart_tx_engine
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BIT_TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  READY,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  frm_par_en_q, frm_par_en_d;
  logic                  frm_stop2_q, frm_stop2_d;
  logic                  parity_q, parity_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  frame_cfg_t            hold_cfg_q, hold_cfg_d;
  logic                  hold_vld_q, hold_vld_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  load;
  logic                  hold_parity;

  uart_tx_parity #(
    .WIDTH(DATA_WIDTH)
  ) u_parity (
    .data_i   (hold_data_q),
    .par_typ_i(hold_cfg_q.par_typ),
    .parity_o (hold_parity)
  );

  // Next-state logic: buffer accept, bit sequencing and frame load on ticks.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    frm_par_en_d = frm_par_en_q;
    frm_stop2_d  = frm_stop2_q;
    parity_d     = parity_q;
    hold_data_d  = hold_data_q;
    hold_cfg_d   = hold_cfg_q;
    hold_vld_d   = hold_vld_q;
    done_d       = 1'b0;
    load         = 1'b0;
    accept       = DATA_VALID && !hold_vld_q;

    unique case (state_q)
      IDLE: begin
        if (BIT_TICK && hold_vld_q) begin
          load = 1'b1;
        end
      end
      START: begin
        if (BIT_TICK) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (BIT_TICK) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = frm_par_en_q ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (BIT_TICK) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (BIT_TICK) begin
          if (frm_stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (hold_vld_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d      = START;
      shift_d      = hold_data_q;
      bit_cnt_d    = '0;
      stop_cnt_d   = 1'b0;
      frm_par_en_d = hold_cfg_q.par_en;
      frm_stop2_d  = hold_cfg_q.stop2;
      parity_d     = hold_parity;
      hold_vld_d   = 1'b0;
    end

    if (accept) begin
      hold_data_d        = P_DATA;
      hold_cfg_d.par_en  = PAR_EN;
      hold_cfg_d.par_typ = PAR_TYP;
      hold_cfg_d.stop2   = STOP2;
      hold_vld_d         = 1'b1;
    end

    unique case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = parity_d;
      default: tx_out_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any frame and empties the buffer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      frm_par_en_q <= 1'b0;
      frm_stop2_q  <= 1'b0;
      parity_q     <= 1'b0;
      hold_data_q  <= '0;
      hold_cfg_q   <= '0;
      hold_vld_q   <= 1'b0;
      tx_out_q     <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      frm_par_en_q <= frm_par_en_d;
      frm_stop2_q  <= frm_stop2_d;
      parity_q     <= parity_d;
      hold_data_q  <= hold_data_d;
      hold_cfg_q   <= hold_cfg_d;
      hold_vld_q   <= hold_vld_d;
      tx_out_q     <= tx_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign READY  = !hold_vld_q;
  assign TX_OUT = tx_out_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine: directed frame scenarios plus a randomized run
// against a bit-queue reference model of the serial line.
module tb_uart_tx_engine;

  localparam int DW = 8;

  typedef logic bitq_t[$];

  logic          CLK = 1'b0;
  logic          RST;
  logic          BIT_TICK;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          STOP2;
  logic          READY;
  logic          TX_OUT;
  logic          BUSY;
  logic          DONE;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] cfg_data;
  logic          cfg_pen;
  logic          cfg_ptyp;
  logic          cfg_st2;

  bitq_t cur_m;
  bitq_t hold_m;
  logic  hold_vld_m;
  logic  exp_tx;
  logic  exp_busy;
  logic  exp_done;
  logic  exp_ready;

  uart_tx_engine #(
    .DATA_WIDTH(DW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BIT_TICK  (BIT_TICK),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .STOP2     (STOP2),
    .READY     (READY),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  // Free-running system clock.
  always #5 CLK = ~CLK;

  // Line bits of one frame in transmission order.
  function automatic bitq_t build_frame(input logic [DW-1:0] d, input logic pen,
                                        input logic ptyp, input logic st2);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    if (pen) q.push_back((^d) ^ ptyp);
    q.push_back(1'b1);
    if (st2) q.push_back(1'b1);
    return q;
  endfunction

  // First n bits of a queue packed LSB-first.
  function automatic logic [31:0] pack_bits(input bitq_t q, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = (i < q.size()) ? q[i] : 1'bx;
    return v;
  endfunction

  // One clock: drive inputs at negedge, advance the model at posedge, return at negedge.
  task automatic step(input logic tick, input logic dv, input logic rst);
    logic old_hold;
    BIT_TICK   = tick;
    DATA_VALID = dv;
    RST        = rst;
    P_DATA     = cfg_data;
    PAR_EN     = cfg_pen;
    PAR_TYP    = cfg_ptyp;
    STOP2      = cfg_st2;
    @(posedge CLK);
    exp_done = 1'b0;
    if (rst) begin
      cur_m.delete();
      hold_vld_m = 1'b0;
    end else begin
      old_hold = hold_vld_m;
      if (tick) begin
        if (cur_m.size() != 0) begin
          void'(cur_m.pop_front());
          if (cur_m.size() == 0) begin
            exp_done = 1'b1;
            if (old_hold) begin
              cur_m      = hold_m;
              hold_vld_m = 1'b0;
            end
          end
        end else if (old_hold) begin
          cur_m      = hold_m;
          hold_vld_m = 1'b0;
        end
      end
      if (dv && !old_hold) begin
        hold_m     = build_frame(cfg_data, cfg_pen, cfg_ptyp, cfg_st2);
        hold_vld_m = 1'b1;
      end
    end
    exp_tx    = (cur_m.size() != 0) ? cur_m[0] : 1'b1;
    exp_busy  = (cur_m.size() != 0);
    exp_ready = !hold_vld_m;
    @(negedge CLK);
  endtask

  // Offer one frame from idle and tick at the given period until DONE or a bound.
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                            input logic st2, input int period, output bitq_t bits,
                            output int done_tick, output int busy_ticks,
                            output logic ready_after_load);
    cfg_data = d; cfg_pen = pen; cfg_ptyp = ptyp; cfg_st2 = st2;
    bits.delete();
    done_tick        = -1;
    busy_ticks       = 0;
    ready_after_load = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 24; t++) begin
      step(1'b1, 1'b0, 1'b0);
      if (t == 0) ready_after_load = READY;
      bits.push_back(TX_OUT);
      if (BUSY) busy_ticks++;
      if (DONE) begin
        done_tick = t;
        break;
      end
      repeat (period - 1) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Reset values of every output.
  task automatic test_reset();
    cfg_data = '0; cfg_pen = 1'b0; cfg_ptyp = 1'b0; cfg_st2 = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (TX_OUT !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: got %b expected 1", TX_OUT); end
    checks++;
    if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
    checks++;
    if (READY !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", READY); end
    checks++;
    if (DONE !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", DONE); end
  endtask

  // 0xA5, even parity, one stop bit, tick every 4 clocks.
  task automatic test_frame_a5();
    bitq_t bits;
    int    done_tick, busy_ticks, extra_done;
    logic  rdy;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 4, bits, done_tick, busy_ticks, rdy);
    checks++;
    if (pack_bits(bits, 11) !== 32'h54A) begin
      failures++; $display("[TB] FAIL a5_bits: got %h expected %h", pack_bits(bits, 11), 32'h54A);
    end
    checks++;
    if (done_tick !== 11) begin failures++; $display("[TB] FAIL a5_done_tick: got %0d expected 11", done_tick); end
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("[TB] FAIL a5_ready_after_load: got %b expected 1", rdy); end
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      step(i[1], 1'b0, 1'b0);
      if (DONE) extra_done++;
    end
    checks++;
    if (extra_done !== 0) begin failures++; $display("[TB] FAIL a5_single_done: got %0d extra pulses expected 0", extra_done); end
  endtask

  // Parity bit of 0x01 under odd and even parity.
  task automatic test_parity();
    bitq_t bits;
    int    done_tick, busy_ticks;
    logic  rdy;
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1, bits, done_tick, busy_ticks, rdy);
    checks++;
    if (bits[9] !== 1'b0) begin failures++; $display("[TB] FAIL odd_parity_bit: got %b expected 0", bits[9]); end
    checks++;
    if (done_tick !== 11) begin failures++; $display("[TB] FAIL odd_done_tick: got %0d expected 11", done_tick); end
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1, bits, done_tick, busy_ticks, rdy);
    checks++;
    if (bits[9] !== 1'b1) begin failures++; $display("[TB] FAIL even_parity_bit: got %b expected 1", bits[9]); end
  endtask

  // No parity, two stop bits, 0xFF.
  task automatic test_stop2();
    bitq_t bits;
    int    done_tick, busy_ticks;
    logic  rdy;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 3, bits, done_tick, busy_ticks, rdy);
    checks++;
    if (pack_bits(bits, 11) !== 32'h7FE) begin
      failures++; $display("[TB] FAIL stop2_bits: got %h expected %h", pack_bits(bits, 11), 32'h7FE);
    end
    checks++;
    if (done_tick !== 11) begin failures++; $display("[TB] FAIL stop2_done_tick: got %0d expected 11", done_tick); end
    checks++;
    if (busy_ticks !== 11) begin failures++; $display("[TB] FAIL stop2_busy_ticks: got %0d expected 11", busy_ticks); end
  endtask

  // Second byte accepted mid-frame follows with no idle bit; a third byte offered
  // while the buffer is full is dropped.
  task automatic test_back_to_back();
    bitq_t obs, exp_q, f2;
    int    done1, done2, late_busy;
    logic  third, rdy9, rdy10;
    obs.delete();
    done1 = -1; done2 = -1; late_busy = 0; third = 1'b0; rdy9 = 1'bx; rdy10 = 1'bx;
    exp_q = build_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    f2    = build_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    foreach (f2[i]) exp_q.push_back(f2[i]);
    cfg_data = 8'hA5; cfg_pen = 1'b0; cfg_ptyp = 1'b0; cfg_st2 = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 30; t++) begin
      step(1'b1, third, 1'b0);
      if (t < 20) obs.push_back(TX_OUT);
      if (DONE && done1 < 0) done1 = t;
      else if (DONE) done2 = t;
      if (t == 9) rdy9 = READY;
      if (t == 10) begin
        rdy10 = READY;
        third = 1'b0;
      end
      if (t > 20 && BUSY) late_busy++;
      if (t == 3) begin
        cfg_data = 8'h3C;
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (READY !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_fall: got %b expected 0", READY); end
        cfg_data = 8'h99;
        third    = 1'b1;
      end else begin
        step(1'b0, third, 1'b0);
      end
    end
    checks++;
    if (pack_bits(obs, 20) !== pack_bits(exp_q, 20)) begin
      failures++; $display("[TB] FAIL b2b_stream: got %h expected %h", pack_bits(obs, 20), pack_bits(exp_q, 20));
    end
    checks++;
    if (done1 !== 10) begin failures++; $display("[TB] FAIL b2b_done1: got %0d expected 10", done1); end
    checks++;
    if (done2 !== 20) begin failures++; $display("[TB] FAIL b2b_done2: got %0d expected 20", done2); end
    checks++;
    if (rdy9 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_before_load: got %b expected 0", rdy9); end
    checks++;
    if (rdy10 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_rise: got %b expected 1", rdy10); end
    checks++;
    if (late_busy !== 0) begin failures++; $display("[TB] FAIL b2b_third_dropped: got %0d busy ticks expected 0", late_busy); end
  endtask

  // Accept and tick on the same edge in IDLE: start bit one tick later.
  task automatic test_accept_tick_idle();
    int seen_done;
    cfg_data = 8'h5A; cfg_pen = 1'b0; cfg_ptyp = 1'b0; cfg_st2 = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      failures++; $display("[TB] FAIL same_edge_no_start: got tx=%b busy=%b expected tx=1 busy=0", TX_OUT, BUSY);
    end
    checks++;
    if (READY !== 1'b0) begin failures++; $display("[TB] FAIL same_edge_buffered: got %b expected 0", READY); end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (TX_OUT !== 1'b0 || BUSY !== 1'b1) begin
      failures++; $display("[TB] FAIL same_edge_start_next: got tx=%b busy=%b expected tx=0 busy=1", TX_OUT, BUSY);
    end
    seen_done = -1;
    for (int t = 0; t < 20 && seen_done < 0; t++) begin
      step(1'b1, 1'b0, 1'b0);
      if (DONE) seen_done = t;
    end
    checks++;
    if (seen_done !== 9) begin failures++; $display("[TB] FAIL same_edge_done: got %0d expected 9", seen_done); end
  endtask

  // Reset in the middle of the data bits, then a fresh frame.
  task automatic test_reset_mid_frame();
    bitq_t bits;
    int    done_tick, busy_ticks, bad;
    logic  rdy;
    cfg_data = 8'hA5; cfg_pen = 1'b1; cfg_ptyp = 1'b0; cfg_st2 = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    cfg_data = 8'h77;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (TX_OUT !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_tx: got %b expected 1", TX_OUT); end
    checks++;
    if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", BUSY); end
    checks++;
    if (READY !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", READY); end
    checks++;
    if (DONE !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_done: got %b expected 0", DONE); end
    bad = 0;
    for (int t = 0; t < 15; t++) begin
      step(1'b1, 1'b0, 1'b0);
      if (DONE || BUSY || TX_OUT !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("[TB] FAIL rst_mid_discard: got %0d active ticks expected 0", bad); end
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 2, bits, done_tick, busy_ticks, rdy);
    checks++;
    if (pack_bits(bits, 11) !== pack_bits(build_frame(8'h55, 1'b1, 1'b0, 1'b0), 11)) begin
      failures++; $display("[TB] FAIL rst_fresh_bits: got %h expected %h", pack_bits(bits, 11),
                           pack_bits(build_frame(8'h55, 1'b1, 1'b0, 1'b0), 11));
    end
    checks++;
    if (done_tick !== 11) begin failures++; $display("[TB] FAIL rst_fresh_done: got %0d expected 11", done_tick); end
  endtask

  // Random traffic, configs, tick patterns and occasional resets against the model.
  task automatic test_random();
    logic tick, dv, rst, always_tick;
    for (int c = 0; c < 1500; c++) begin
      always_tick = (c >= 600 && c < 900);
      tick = always_tick ? 1'b1 : ($urandom_range(0, 2) == 0);
      dv   = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      cfg_data = DW'($urandom);
      cfg_pen  = 1'($urandom);
      cfg_ptyp = 1'($urandom);
      cfg_st2  = 1'($urandom);
      step(tick, dv, rst);
      checks++;
      if (TX_OUT !== exp_tx) begin failures++; $display("[TB] FAIL rand_tx cycle %0d: got %b expected %b", c, TX_OUT, exp_tx); end
      checks++;
      if (BUSY !== exp_busy) begin failures++; $display("[TB] FAIL rand_busy cycle %0d: got %b expected %b", c, BUSY, exp_busy); end
      checks++;
      if (DONE !== exp_done) begin failures++; $display("[TB] FAIL rand_done cycle %0d: got %b expected %b", c, DONE, exp_done); end
      checks++;
      if (READY !== exp_ready) begin failures++; $display("[TB] FAIL rand_ready cycle %0d: got %b expected %b", c, READY, exp_ready); end
    end
  endtask

  // Test sequence.
  initial begin
    RST = 1'b1; BIT_TICK = 1'b0; DATA_VALID = 1'b0; P_DATA = '0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    hold_vld_m = 1'b0;
    exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_ready = 1'b1;
    @(negedge CLK);
    test_reset();
    test_frame_a5();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_accept_tick_idle();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
